// File: rtl/mips_pkg.sv
// Shared definitions for the register file: default widths and the debug FSM encoding.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    DBG_IDLE   = 2'd0,
    DBG_DRAIN  = 2'd1,
    DBG_ACCESS = 2'd2,
    DBG_ACK    = 2'd3
  } dbg_state_e;

  // Counter width able to hold n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Host debug port of the register file: 4-phase level handshake plus read/write data.
interface register_file_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_stall;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  modport master (
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_stall, dbg_ack, dbg_rdata
  );

  modport slave (
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_stall, dbg_ack, dbg_rdata
  );

endinterface

// File: rtl/regfile_dbg_ctrl.sv
// Debug access sequencer: freezes the pipeline for DRAIN_CYC cycles, performs one
// array access, then holds ack until the host releases its request.
module regfile_dbg_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_stall,
  output logic              dbg_ack,
  output logic              acc_en,
  output logic              acc_we,
  output logic [ADDR_W-1:0] acc_addr,
  output logic [DATA_W-1:0] acc_wdata
);

  localparam int               CNT_W    = cnt_width(DRAIN_CYC);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYC - 1);

  dbg_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              latch;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= DBG_IDLE;
      cnt    <= '0;
      lat_we <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch) lat_we <= dbg_we;
    end
  end

  // Address/data are only meaningful once latched, so they carry no reset.
  always_ff @(posedge clk) begin
    if (latch) begin
      lat_addr  <= dbg_addr;
      lat_wdata <= dbg_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    dbg_stall = 1'b0;
    dbg_ack   = 1'b0;
    acc_en    = 1'b0;
    case (state)
      DBG_IDLE: begin
        if (dbg_req) begin
          latch     = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = DBG_DRAIN;
        end
      end
      DBG_DRAIN: begin
        dbg_stall = 1'b1;
        if (cnt == '0) state_nxt = DBG_ACCESS;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      DBG_ACCESS: begin
        dbg_stall = 1'b1;
        acc_en    = 1'b1;
        state_nxt = DBG_ACK;
      end
      DBG_ACK: begin
        dbg_ack = 1'b1;
        if (!dbg_req) state_nxt = DBG_IDLE;
      end
      default: state_nxt = DBG_IDLE;
    endcase
  end

  assign acc_we    = lat_we;
  assign acc_addr  = lat_addr;
  assign acc_wdata = lat_wdata;

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file with write-through bypass and a host debug
// port that can read or write any register while the pipeline is frozen.
module register_file
  import mips_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  output logic [DATA_W-1:0] reg1val,
  output logic [DATA_W-1:0] reg2val,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  register_file_if.slave    dbg
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              stall, ack;
  logic              acc_en, acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] rdata;
  logic              wb_hit, dbg_hit;

  regfile_dbg_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DRAIN_CYC(DRAIN_CYC)
  ) u_dbg_ctrl (
    .clk      (clk),
    .rst      (rst),
    .dbg_req  (dbg.dbg_req),
    .dbg_we   (dbg.dbg_we),
    .dbg_addr (dbg.dbg_addr),
    .dbg_wdata(dbg.dbg_wdata),
    .dbg_stall(stall),
    .dbg_ack  (ack),
    .acc_en   (acc_en),
    .acc_we   (acc_we),
    .acc_addr (acc_addr),
    .acc_wdata(acc_wdata)
  );

  // A same-cycle write-back is forwarded so decode never sees a stale value.
  assign reg1val = (src1 == '0) ? '0 : (wb_en && wb_dest == src1) ? wb_value : regs[src1];
  assign reg2val = (src2 == '0) ? '0 : (wb_en && wb_dest == src2) ? wb_value : regs[src2];

  assign wb_hit  = wb_en && (wb_dest != '0);
  assign dbg_hit = acc_en && acc_we && (acc_addr != '0);

  // The debug write is issued last so it overrides a colliding write-back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wb_hit)  regs[wb_dest]  <= wb_value;
      if (dbg_hit) regs[acc_addr] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                  rdata <= '0;
    else if (acc_en && !acc_we) rdata <= (acc_addr == '0) ? '0 : regs[acc_addr];
  end

  assign dbg.dbg_stall = stall;
  assign dbg.dbg_ack   = ack;
  assign dbg.dbg_rdata = rdata;

endmodule

// File: tb/tb_register_file.sv
// Randomized scoreboard bench for register_file against a transaction-level reference model.
module tb_register_file;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int D    = 2;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] src1, src2, wb_dest;
  logic [DW-1:0] reg1val, reg2val, wb_value;
  logic          wb_en;

  register_file_if #(.DATA_W(DW), .ADDR_W(AW)) dbg_bus ();

  register_file #(.DATA_W(DW), .ADDR_W(AW), .DRAIN_CYC(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .src1    (src1),
    .src2    (src2),
    .reg1val (reg1val),
    .reg2val (reg2val),
    .wb_en   (wb_en),
    .wb_dest (wb_dest),
    .wb_value(wb_value),
    .dbg     (dbg_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] rdata;
    logic          stall;
    logic          ack;
  } exp_t;

  exp_t chk_q[$];
  int   ack_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: register contents plus one outstanding debug transaction.
  logic [DW-1:0] mdl [NREG];
  int            busy = 0;
  bit            in_ack = 1'b0;
  bit            lat_we = 1'b0;
  logic [AW-1:0] lat_addr = '0;
  logic [DW-1:0] lat_wdata = '0;
  logic [DW-1:0] rdata_m = '0;
  int            issue_edge = 0;
  int            model_edge = 0;
  int            mon_edge = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, mon_edge);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (wb_en && wb_dest == a) return wb_value;
    return mdl[a];
  endfunction

  task automatic model_step();
    bit            start, leave, do_acc;
    logic [DW-1:0] cap;
    model_edge++;
    if (rst !== 1'b1) begin
      for (int i = 0; i < NREG; i++) mdl[i] = '0;
      busy    = 0;
      in_ack  = 1'b0;
      rdata_m = '0;
      return;
    end
    start  = (busy == 0) && !in_ack && (dbg_bus.dbg_req === 1'b1);
    leave  = in_ack && (dbg_bus.dbg_req !== 1'b1);
    do_acc = (busy == 1);
    cap    = (lat_addr == '0) ? '0 : mdl[lat_addr];
    if (wb_en && wb_dest != '0) mdl[wb_dest] = wb_value;
    if (do_acc) begin
      if (lat_we && lat_addr != '0) mdl[lat_addr] = lat_wdata;
      if (!lat_we) rdata_m = cap;
      in_ack = 1'b1;
      ack_q.push_back(issue_edge + D + 1);
    end
    if (busy > 0) busy--;
    if (leave) in_ack = 1'b0;
    if (start) begin
      lat_we     = dbg_bus.dbg_we;
      lat_addr   = dbg_bus.dbg_addr;
      lat_wdata  = dbg_bus.dbg_wdata;
      busy       = D + 1;
      issue_edge = model_edge;
    end
  endtask

  task automatic cycle(input bit chk_en);
    exp_t e;
    if (chk_en) begin
      e.r1    = ref_read(src1);
      e.r2    = ref_read(src2);
      e.stall = (busy > 0);
      e.ack   = in_ack;
      e.rdata = rdata_m;
      chk_q.push_back(e);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic dbg_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int wb_at, input logic [AW-1:0] wd, input logic [DW-1:0] wv);
    dbg_bus.dbg_we    = we;
    dbg_bus.dbg_addr  = a;
    dbg_bus.dbg_wdata = d;
    for (int k = 0; k <= D + 1; k++) begin
      dbg_bus.dbg_req = 1'b1;
      wb_en    = (k == wb_at);
      wb_dest  = wd;
      wb_value = wv;
      cycle(1);
      dbg_bus.dbg_addr  = ~a;
      dbg_bus.dbg_wdata = ~d;
    end
    wb_en = 1'b0;
    cycle(1);
    dbg_bus.dbg_req = 1'b0;
    cycle(1);
    cycle(1);
  endtask

  always @(posedge clk) mon_edge++;

  exp_t mon_e;
  logic prev_ack = 1'b0;

  always @(negedge clk) begin
    if (chk_q.size() > 0) begin
      mon_e = chk_q.pop_front();
      chk("reg1val", reg1val, mon_e.r1);
      chk("reg2val", reg2val, mon_e.r2);
      chk("dbg_stall", DW'(dbg_bus.dbg_stall), DW'(mon_e.stall));
      chk("dbg_ack", DW'(dbg_bus.dbg_ack), DW'(mon_e.ack));
      chk("dbg_rdata", dbg_bus.dbg_rdata, mon_e.rdata);
      if (dbg_bus.dbg_ack === 1'b1 && prev_ack !== 1'b1) begin
        if (ack_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ack_unexpected: got ack at edge %0d, required none", mon_edge);
        end else begin
          chk("ack_latency", DW'(mon_edge), DW'(ack_q.pop_front()));
        end
      end
    end
    prev_ack = dbg_bus.dbg_ack;
  end

  initial begin
    rst = 1'b0;
    src1 = '0; src2 = '0;
    wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    dbg_bus.dbg_req = 1'b0; dbg_bus.dbg_we = 1'b0;
    dbg_bus.dbg_addr = '0; dbg_bus.dbg_wdata = '0;

    cycle(0);
    cycle(1);
    cycle(1);
    rst = 1'b1;

    // Every register reads zero after reset; r0 ignores writes.
    for (int i = 0; i < NREG; i++) begin
      src1 = AW'(i);
      src2 = AW'(NREG - 1 - i);
      cycle(1);
    end
    wb_en = 1'b1; wb_dest = '0; wb_value = '1; src1 = '0; src2 = '0;
    cycle(1);
    wb_en = 1'b0;
    cycle(1);

    // Write-through bypass, then the stored value.
    wb_en = 1'b1; wb_dest = 5'd5; wb_value = 32'h1234_5678; src1 = 5'd5;
    cycle(1);
    wb_en = 1'b0;
    cycle(1);

    // Debug write r9, read it back on port 2.
    src2 = 5'd9;
    dbg_access(1'b1, 5'd9, 32'hCAFE_F00D, -1, '0, '0);
    cycle(1);

    // Debug read of r9 with a write-back to r9 during drain.
    dbg_access(1'b0, 5'd9, '0, 1, 5'd9, 32'h11);

    // Debug write and write-back collide on r3 in the access cycle.
    src1 = 5'd3;
    dbg_access(1'b1, 5'd3, 32'hAA, D + 1, 5'd3, 32'hBB);
    cycle(1);

    // Reset during drain of a debug write to r7.
    wb_en = 1'b1; wb_dest = 5'd7; wb_value = 32'h77; src1 = 5'd7;
    cycle(1);
    wb_en = 1'b0;
    dbg_bus.dbg_req = 1'b1; dbg_bus.dbg_we = 1'b1;
    dbg_bus.dbg_addr = 5'd7; dbg_bus.dbg_wdata = 32'h55;
    cycle(1);
    rst = 1'b0;
    cycle(1);
    rst = 1'b1;
    dbg_bus.dbg_req = 1'b0;
    cycle(1);
    cycle(1);

    // Request dropped after one cycle still completes with a single ack cycle.
    wb_en = 1'b1; wb_dest = 5'd4; wb_value = 32'hDEAD_BEEF;
    cycle(1);
    wb_en = 1'b0;
    dbg_bus.dbg_req = 1'b1; dbg_bus.dbg_we = 1'b0; dbg_bus.dbg_addr = 5'd4;
    cycle(1);
    dbg_bus.dbg_req = 1'b0;
    repeat (D + 3) cycle(1);

    // Randomized traffic.
    repeat (500) begin
      rst      = ($urandom_range(99) != 0);
      src1     = AW'($urandom);
      src2     = AW'($urandom_range(7));
      wb_en    = $urandom_range(1) == 1;
      wb_dest  = ($urandom_range(3) == 0) ? lat_addr : AW'($urandom_range(7));
      wb_value = $urandom;
      dbg_bus.dbg_we    = $urandom_range(1) == 1;
      dbg_bus.dbg_addr  = AW'($urandom_range(7));
      dbg_bus.dbg_wdata = $urandom;
      if (busy == 0 && !in_ack) dbg_bus.dbg_req = ($urandom_range(3) == 0);
      else if (in_ack)          dbg_bus.dbg_req = ($urandom_range(1) == 0);
      else                      dbg_bus.dbg_req = ($urandom_range(7) != 0);
      cycle(1);
    end

    rst = 1'b1; wb_en = 1'b0; dbg_bus.dbg_req = 1'b0;
    repeat (D + 4) cycle(1);

    total++;
    if (ack_q.size() != 0 || chk_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d acks outstanding, required 0", ack_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
